// File: rtl/bram_xfer_ctrl.sv
// Backup-RAM image sequencer: SD sector save/load, format pattern, load hold.
// Optional autosave with pending-write tracking: define BRAM_AUTOSAVE_EN.
`timescale 1ns/1ps
module bram_xfer_ctrl #(
    parameter int SECTORS = 16,
    parameter int LBA_W   = 4
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        dl_active,
    input  logic        img_mounted,
    input  logic        img_readonly,
    input  logic        img_size_nz,
    input  logic        load_req,
    input  logic        save_req,
    input  logic        format_req,
    input  logic        osd_open,
    input  logic        autosave_on,
    input  logic        bram_wr,
    input  logic        sd_ack,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    output logic        portb_sd,
    output logic [1:0]  fmt_addr,
    output logic [15:0] fmt_data,
    output logic        fmt_we,
    output logic        ena,
    output logic        busy,
    output logic        loading,
    output logic        pending
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK, S_FMT} state_t;

    state_t r_state;
    state_t w_next;

    logic r_dl_d, r_load_d, r_save_d, r_fmt_d, r_ack_d, r_auto_d;
    logic r_ena, r_pending, r_loading, r_dir_load;
    logic r_sd_rd, r_sd_wr, r_portb;
    logic [LBA_W-1:0] r_lba;
    logic [1:0] r_fcnt;

    logic w_auto, w_dl_rise, w_dl_fall, w_load_go, w_save_rise;
    logic w_fmt_rise, w_ack_rise, w_ack_fall, w_start, w_last;
    logic [15:0] w_fmt_word;

`ifdef BRAM_AUTOSAVE_EN
    assign w_auto = r_pending & osd_open & autosave_on;
`else
    logic w_unused;
    assign w_auto   = 1'b0;
    assign w_unused = &{1'b0, osd_open, autosave_on, bram_wr};
`endif

    assign w_dl_rise   = dl_active & ~r_dl_d;
    assign w_dl_fall   = ~dl_active & r_dl_d;
    assign w_load_go   = (load_req & ~r_load_d) | (w_dl_fall & img_size_nz);
    assign w_save_rise = (save_req & ~r_save_d) | (w_auto & ~r_auto_d);
    assign w_fmt_rise  = format_req & ~r_fmt_d;
    assign w_ack_rise  = sd_ack & ~r_ack_d;
    assign w_ack_fall  = ~sd_ack & r_ack_d;
    assign w_last      = (r_lba == LBA_W'(SECTORS - 1));

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (r_ena & (w_load_go | w_save_rise)) begin
                    w_next  = S_REQ;
                    w_start = 1'b1;
                end else if (w_fmt_rise) begin
                    w_next = S_FMT;
                end
            end
            S_REQ: if (w_ack_rise) w_next = S_ACK;
            S_ACK: if (w_ack_fall) w_next = w_last ? S_IDLE : S_REQ;
            S_FMT: if (r_fcnt == 2'd3) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_fmt_word = 16'h0000;
        unique case (r_fcnt)
            2'd0: w_fmt_word = 16'h5548;
            2'd1: w_fmt_word = 16'h4D42;
            2'd2: w_fmt_word = 16'h8800;
            2'd3: w_fmt_word = 16'h8010;
            default: w_fmt_word = 16'h0000;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_dl_d     <= 1'b0;
            r_load_d   <= 1'b0;
            r_save_d   <= 1'b0;
            r_fmt_d    <= 1'b0;
            r_ack_d    <= 1'b0;
            r_auto_d   <= 1'b0;
            r_ena      <= 1'b0;
            r_pending  <= 1'b0;
            r_loading  <= 1'b0;
            r_dir_load <= 1'b0;
            r_sd_rd    <= 1'b0;
            r_sd_wr    <= 1'b0;
            r_portb    <= 1'b0;
            r_lba      <= '0;
            r_fcnt     <= 2'd0;
        end else begin
            r_state  <= w_next;
            r_dl_d   <= dl_active;
            r_load_d <= load_req;
            r_save_d <= save_req;
            r_fmt_d  <= format_req;
            r_ack_d  <= sd_ack;
            r_auto_d <= w_auto;
            r_portb  <= (w_next != S_FMT);
            r_fcnt   <= (r_state == S_FMT) ? r_fcnt + 2'd1 : 2'd0;
            // request is a registered image of REQ so lba settles first
            r_sd_rd  <= (r_state == S_REQ) & r_dir_load;
            r_sd_wr  <= (r_state == S_REQ) & ~r_dir_load;
            if (dl_active & img_mounted & ~img_readonly)
                r_ena <= 1'b1;
            else if (w_dl_rise)
                r_ena <= 1'b0;
`ifdef BRAM_AUTOSAVE_EN
            if (r_ena & ~osd_open & bram_wr)
                r_pending <= 1'b1;
            else if (w_start)
                r_pending <= 1'b0;
`else
            r_pending <= 1'b0;
`endif
            if (w_start) begin
                r_lba      <= '0;
                r_dir_load <= w_load_go;
                r_loading  <= w_load_go;
            end else if ((r_state == S_ACK) && w_ack_fall) begin
                if (w_last)
                    r_loading <= 1'b0;
                else
                    r_lba <= r_lba + 1'b1;
            end
        end
    end

    assign sd_lba   = {{(32 - LBA_W){1'b0}}, r_lba};
    assign sd_rd    = r_sd_rd;
    assign sd_wr    = r_sd_wr;
    assign portb_sd = r_portb;
    assign fmt_we   = (r_state == S_FMT);
    assign fmt_addr = r_fcnt;
    assign fmt_data = fmt_we ? w_fmt_word : 16'h0000;
    assign ena      = r_ena;
    assign busy     = (r_state == S_REQ) || (r_state == S_ACK);
    assign loading  = r_loading;
    assign pending  = r_pending;

endmodule

// File: doc/bram_xfer_ctrl.md
# bram_xfer_ctrl

Sequencer for the backup-RAM save/load path. Moves the 16-sector (8 KiB) backup image between the SD/HPS sector interface and port B of the backup-RAM dual-port pair. Also sequences the format pattern write, and raises the core-hold signal while a load is in progress. Sits in `emu` between `hps_io` (sd_* signals) and the backram port-B address/data muxes.

## Interface
Parameters
- `SECTORS`, 16: sectors per image; must be a power of two, 2..256.
- `LBA_W`, 4: `log2(SECTORS)`; width of the internal sector counter.

Ports
- `clk_sys`  in  1: system clock; all logic on its rising edge.
- `reset_n`  in  1: reset, asynchronous, active-low.
- `dl_active`  in  1: cartridge download in progress.
- `img_mounted`  in  1: save image mount strobe from `hps_io`.
- `img_readonly`  in  1: mounted image is read-only.
- `img_size_nz`  in  1: mounted image size is non-zero.
- `load_req`  in  1: OSD load command (level; rising edge acts).
- `save_req`  in  1: OSD save command (level; rising edge acts).
- `format_req`  in  1: OSD format command (level; rising edge acts).
- `osd_open`  in  1: OSD visible.
- `autosave_on`  in  1: autosave option enabled.
- `bram_wr`  in  1: core write strobe to backup RAM port A.
- `sd_ack`  in  1: HPS sector transfer acknowledge.
- `sd_lba`  out  32: sector address; bits above `LBA_W` are 0.
- `sd_rd`  out  1: sector read request.
- `sd_wr`  out  1: sector write request.
- `portb_sd`  out  1: 1 = port B driven by the SD buffer; 0 = driven by the format pattern.
- `fmt_addr`  out  2: format word address.
- `fmt_data`  out  16: format word.
- `fmt_we`  out  1: format write strobe.
- `ena`  out  1: backup save/load allowed.
- `busy`  out  1: transfer in progress.
- `loading`  out  1: load in progress; drives core reset.
- `pending`  out  1: unsaved core writes exist.

## Operation
- Edge detectors hold a 1-cycle-delayed copy of `dl_active`, `load_req`, `save_req`, `format_req`, `sd_ack` and the autosave trigger. All of these reset to 0.
- `ena`:
  - cleared on the rising edge of `dl_active`;
  - set on any cycle where `dl_active & img_mounted & ~img_readonly`;
  - if both conditions hold in the same cycle, set wins.
- FSM states: IDLE, REQ, ACK, FMT.
- IDLE → REQ on any of the following, provided `ena`=1:
  - rising edge of `load_req` → load;
  - rising edge of the save trigger → save;
  - falling edge of `dl_active` with `img_size_nz` → load.
  - Simultaneous triggers: load wins.
  - On entry: `sd_lba`=0, `loading`=direction; `sd_rd`=load, `sd_wr`=save.
- REQ → ACK on the `sd_ack` rising edge; `sd_rd` and `sd_wr` are cleared in that cycle.
- ACK on the `sd_ack` falling edge:
  - if `sd_lba[LBA_W-1:0]` is all ones → IDLE, and `loading` is cleared;
  - otherwise `sd_lba`+1, → REQ, and the request is reasserted with the same direction.
- IDLE → FMT on the rising edge of `format_req`; `ena` is not required.
  - FMT runs 4 cycles: `fmt_we`=1, `fmt_addr`=0,1,2,3.
  - `fmt_data` = 16'h5548, 16'h4D42, 16'h8800, 16'h8010 respectively.
  - Then → IDLE.
- `format_req` edges outside IDLE are dropped. `load_req` and `save_req` edges outside IDLE are also dropped.
- `portb_sd` = 0 only in FMT.
- `busy` = 1 in REQ and ACK.

## Timing
- Reset values: all outputs 0; `sd_lba`=0; state IDLE.
  - Asserting `reset_n` mid-transfer drops `sd_rd`/`sd_wr` immediately and aborts with no completion.
- Request latency: `sd_rd`/`sd_wr` rise 2 cycles after the input edge (1 cycle to detect the edge, 1 to register).
- `sd_rd`/`sd_wr` fall 1 cycle after `sd_ack` is seen high in the registered edge detector. They are never both 1.
- The next sector's request rises 2 cycles after `sd_ack` falls.
- `sd_lba` is stable from request assertion through the `sd_ack` fall.
- `loading` is 1 from the REQ entry cycle until the cycle after the last `sd_ack` fall.
- `sd_ack` pulses arriving in IDLE or FMT are ignored.

## Configuration
- `BRAM_AUTOSAVE_EN` defined:
  - `pending` is set when `ena & ~osd_open & bram_wr`;
  - `pending` is cleared on the cycle the FSM leaves IDLE for REQ; set wins over clear in the same cycle;
  - save trigger = `save_req | (pending & osd_open & autosave_on)`.
- Not defined:
  - `pending` is tied to 0;
  - `autosave_on`, `osd_open` and `bram_wr` are unused;
  - save trigger = `save_req`.

## Test plan
- **Mount, download end, auto-load.** Pulse `dl_active` with `img_mounted`=1 and `img_readonly`=0, then `img_size_nz`=1. Respond to each request with a 3-cycle `sd_ack`. Required: `loading`=1; 16 `sd_rd` requests at `sd_lba` 0..15 and none on `sd_wr`; return to IDLE; `loading`=0.
- **Manual save.** With `ena`=1, raise `save_req`. Required: `sd_wr`=1 two cycles later at `sd_lba`=0; `sd_rd` stays 0 for all 16 sectors; `busy` falls after the 16th `sd_ack` fall.
- **Load/save priority.** `load_req` and `save_req` rise in the same cycle. Required: `sd_rd`=1, `sd_wr`=0. A second `save_req` edge mid-transfer is ignored: exactly 16 requests total.
- **Format.** Raise `format_req` in IDLE. Required: 4 consecutive cycles with `fmt_we`=1, `portb_sd`=0, address/data pairs 0/5548, 1/4D42, 2/8800, 3/8010. The same edge raised during a transfer produces no `fmt_we`.
- **Autosave (macro defined).** `bram_wr` pulse with `osd_open`=0 → `pending`=1. Then `osd_open`=1 with `autosave_on`=1 → save starts and `pending` clears. With `autosave_on`=0, no save occurs.
- **Reset mid-transfer and read-only image.** Drop `reset_n` while in ACK at `sd_lba`=5. Required: `sd_rd`=0, `sd_lba`=0, `loading`=0 within the same cycle. Separately, a read-only mount leaves `ena`=0, and load/save requests are then ignored.
